// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, synchronizes its tap and
// counts rising edges over a fixed window of GATE_CYCLES clk cycles.
module ro_freq_meter #(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 256,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             valid,
  output logic             overflow,
  output logic [CNT_W-1:0] count_out
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, ARM, COUNT, DONE} state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] count_out_q, count_out_d;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic [2:0]       sync_q, sync_d;
  logic             rise;

  // sync_q[0]=s1, [1]=s2, [2]=s3; rise is independent of state
  assign sync_d = {sync_q[1:0], ro_in};
  assign rise   = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    edge_cnt_d  = edge_cnt_q;
    ovf_d       = ovf_q;
    count_out_d = count_out_q;
    overflow_d  = overflow_q;
    valid_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARM;
          timer_d    = TW'(SETTLE_CYCLES - 1);
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      ARM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (timer_q == '0) begin
          state_d = COUNT;
          timer_d = TW'(GATE_CYCLES - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // saturate instead of wrapping; a lost edge is flagged as overflow
          if (rise) begin
            if (&edge_cnt_q) ovf_d = 1'b1;
            else             edge_cnt_d = edge_cnt_q + CNT_W'(1);
          end
          if (timer_q == '0) state_d = DONE;
          else               timer_d = timer_q - TW'(1);
        end
      end
      DONE: begin
        count_out_d = edge_cnt_q;
        overflow_d  = ovf_q;
        valid_d     = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      edge_cnt_q  <= '0;
      ovf_q       <= 1'b0;
      count_out_q <= '0;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      sync_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      edge_cnt_q  <= edge_cnt_d;
      ovf_q       <= ovf_d;
      count_out_q <= count_out_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      sync_q      <= sync_d;
    end
  end

  assign ro_en     = (state_q == ARM) || (state_q == COUNT);
  assign busy      = (state_q != IDLE);
  assign valid     = valid_q;
  assign overflow  = overflow_q;
  assign count_out = count_out_q;

endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
- Measurement end of the on-chip ring-oscillator path: enables the oscillator, samples its asynchronous output tap, and counts rising edges over a fixed gate window timed in clk cycles.
- Result is a per-run edge count, proportional to oscillator frequency: f_ro = count * f_clk / GATE_CYCLES.
- Sits between the oscillator enable/tap wires and the top-level pin mux.

Parameters:
- CNT_W, 16: width of the edge counter and the result register.
- GATE_CYCLES, 256: length of the counting window in clk cycles (>=1).
- SETTLE_CYCLES, 8: clk cycles between enabling the oscillator and opening the window (>=3, covers the synchronizer fill).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request a measurement; sampled only in IDLE.
- abort  input  1  cancel the run in progress; no result produced.
- ro_in  input  1  oscillator tap, asynchronous to clk.
- ro_en  output  1  oscillator enable; high in ARM and COUNT only.
- busy  output  1  high in any state other than IDLE.
- valid  output  1  one-cycle pulse when count_out is updated.
- overflow  output  1  last result saturated; held with count_out.
- count_out  output  CNT_W  last completed edge count; held until the next completed run.

Behaviour:
- Reset: all state is cleared asynchronously.
  - ro_en=0, busy=0, valid=0, overflow=0, count_out=0.
  - Synchronizer flops=0, counters=0, state=IDLE.
- Synchronizer: three flops s1->s2->s3 on ro_in. rise = s2 & ~s3. Only rise is used downstream.
- FSM states: IDLE, ARM, COUNT, DONE.
  - IDLE: start=1 -> ARM. Load timer with SETTLE_CYCLES-1. Clear edge counter and internal overflow.
  - ARM: ro_en=1. Edges are ignored. When timer==0 -> COUNT, load timer with GATE_CYCLES-1. Otherwise decrement the timer.
  - COUNT: ro_en=1. Each cycle with rise=1 increments the edge counter. When timer==0 -> DONE (the rise in that final cycle is still counted). Otherwise decrement the timer.
  - Counting window is exactly GATE_CYCLES cycles.
  - DONE: ro_en=0. count_out<=edge counter, overflow<=internal overflow, valid=1 for this cycle only. Then -> IDLE.
- Saturation: the edge counter stops at 2^CNT_W-1. A rise arriving while saturated sets internal overflow. No wrap-around.
- Latency: valid is high exactly SETTLE_CYCLES+GATE_CYCLES+1 cycles after the clk edge that samples start=1 in IDLE.
- start:
  - start outside IDLE is ignored (not queued).
  - start held high continuously re-triggers a run from IDLE the cycle after DONE.
- abort:
  - abort=1 in ARM or COUNT -> IDLE on the next edge. ro_en drops, no valid, count_out/overflow unchanged.
  - abort has priority over the timer-expiry transition.
  - abort in IDLE or DONE has no effect.
  - Simultaneous start and abort in IDLE: start wins.
- Async reset mid-run: immediate return to reset values, including count_out.
- Aliasing: frequencies at or above f_clk/2 alias; that is a known limitation, no detection logic.
- The rise pulse depends only on ro_in history, not on the state. Edges already in the pipeline at window open are counted, which is why SETTLE_CYCLES>=3.

Test Plan:
- Reset values: hold rst_n=0 with ro_in toggling -> ro_en=0, busy=0, valid=0, count_out=0, overflow=0.
- Square ro_in, period 8 clk (sync to TB), defaults, pulse start -> valid at start+265 cycles, count_out=32, overflow=0, ro_en high for exactly 264 cycles.
- Period 4 square, repeat run -> count_out=64. ro_in held constant -> count_out=0.
- CNT_W=4, period 4 square -> count_out=15, overflow=1. A following run with ro_in constant -> count_out=0, overflow=0.
- Assert start during COUNT -> ignored, single valid. Assert abort at cycle 100 of COUNT -> busy=0 and ro_en=0 next cycle, no valid, count_out keeps the previous 32.
- Deassert rst_n mid-COUNT, then release and start again -> outputs zeroed asynchronously, the new run returns the correct count (32 at period 8).
